// File: rtl/fpu_addsub_align_if.sv
// Handshake and operand/result bundle of the FPU add/sub alignment stage.
// slave is the alignment block's view; master is the upstream/downstream side.
interface fpu_addsub_align_if #(
    parameter int unsigned SHW = 26
);
    logic           in_valid;
    logic           in_ready;
    logic [31:0]    op_a;
    logic [31:0]    op_b;
    logic           sub;
    logic           out_valid;
    logic           out_ready;
    logic [SHW-1:0] add_a;
    logic [SHW-1:0] add_b;
    logic           add_cin;
    logic           sticky;
    logic           eff_sub;
    logic [7:0]     res_exp;
    logic           res_sign;
    logic           res_nan;
    logic           res_inf;

    modport slave (
        input  in_valid, op_a, op_b, sub, out_ready,
        output in_ready, out_valid, add_a, add_b, add_cin, sticky, eff_sub,
               res_exp, res_sign, res_nan, res_inf
    );

    modport master (
        output in_valid, op_a, op_b, sub, out_ready,
        input  in_ready, out_valid, add_a, add_b, add_cin, sticky, eff_sub,
               res_exp, res_sign, res_nan, res_inf
    );
endinterface

// File: rtl/fpu_addsub_align.sv
// Operand alignment for the binary32 add/sub datapath: unpack, magnitude
// compare/swap (stage 1), right-shift of the smaller significand with sticky
// collection (stage 2). Feeds a 26-bit mantissa adder through valid/ready.
module fpu_addsub_align #(
    parameter int unsigned SHW = 26  // {hidden, frac[22:0], guard, round}
) (
    input logic               clk,
    input logic               rst_n,
    fpu_addsub_align_if.slave bus
);

    // ---------------- Stage 1 combinational: unpack and compare ----------------
    logic           sa, sb;
    logic [7:0]     ea, eb;
    logic [22:0]    fa, fb;
    logic           a_big;
    logic           nan_a, nan_b, inf_a, inf_b;
    logic           sign_big, sign_small;
    logic [7:0]     e_big, e_small, x_big, x_small;
    logic [22:0]    f_big, f_small;
    logic           s1_eff_sub, s1_nan, s1_inf;

    assign sa = bus.op_a[31];
    assign sb = bus.op_b[31] ^ bus.sub;
    assign ea = bus.op_a[30:23];
    assign eb = bus.op_b[30:23];
    assign fa = bus.op_a[22:0];
    assign fb = bus.op_b[22:0];

    // Tie on {e,f} keeps A as the big operand.
    assign a_big = (bus.op_a[30:0] >= bus.op_b[30:0]);

    assign nan_a = (&ea) & (|fa);
    assign nan_b = (&eb) & (|fb);
    assign inf_a = (&ea) & ~(|fa);
    assign inf_b = (&eb) & ~(|fb);

    // Select big/small operand fields
    always_comb begin
        sign_big   = sb;
        sign_small = sa;
        e_big      = eb;
        e_small    = ea;
        f_big      = fb;
        f_small    = fa;
        if (a_big) begin
            sign_big   = sa;
            sign_small = sb;
            e_big      = ea;
            e_small    = eb;
            f_big      = fa;
            f_small    = fb;
        end
    end

    // Zero/subnormal operands use effective exponent 1.
    assign x_big   = (e_big == 8'd0) ? 8'd1 : e_big;
    assign x_small = (e_small == 8'd0) ? 8'd1 : e_small;

    assign s1_eff_sub = sign_big ^ sign_small;
    assign s1_nan     = nan_a | nan_b | (inf_a & inf_b & s1_eff_sub);
    assign s1_inf     = ~s1_nan & (inf_a | inf_b);

    // ---------------- Handshake ----------------
    logic v1_q, v2_q;
    logic adv1, adv2;

    assign adv2         = ~v2_q | bus.out_ready;
    assign adv1         = ~v1_q | adv2;
    assign bus.in_ready = adv1;
    assign bus.out_valid = v2_q;

    // ---------------- Stage 1 registers ----------------
    logic [SHW-1:0] sig_big_q, sig_small_q;
    logic [7:0]     d_q, exp1_q;
    logic           eff_sub1_q, sign1_q, nan1_q, inf1_q;

    // Stage 1: capture compare/swap results when the stage is free or draining
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            sig_big_q   <= '0;
            sig_small_q <= '0;
            d_q         <= 8'd0;
            exp1_q      <= 8'd0;
            eff_sub1_q  <= 1'b0;
            sign1_q     <= 1'b0;
            nan1_q      <= 1'b0;
            inf1_q      <= 1'b0;
        end else if (adv1) begin
            v1_q <= bus.in_valid;
            if (bus.in_valid) begin
                sig_big_q   <= {(|e_big), f_big, 2'b00};
                sig_small_q <= {(|e_small), f_small, 2'b00};
                d_q         <= x_big - x_small;
                exp1_q      <= x_big;
                eff_sub1_q  <= s1_eff_sub;
                sign1_q     <= sign_big;
                nan1_q      <= s1_nan;
                inf1_q      <= s1_inf;
            end
        end
    end

    // ---------------- Stage 2 combinational: align ----------------
    logic [SHW-1:0] shifted;
    logic           shift_sticky;
    logic           special;

    // Right-shift small significand; collect every bit that falls off the end
    always_comb begin
        shifted      = '0;
        shift_sticky = 1'b0;
        if (d_q >= 8'(SHW)) begin
            shift_sticky = |sig_small_q;
        end else begin
            shifted      = sig_small_q >> d_q;
            shift_sticky = |(sig_small_q & ~({SHW{1'b1}} << d_q));
        end
    end

    assign special = nan1_q | inf1_q;

    // Stage 2: register adder operands; specials force a quiet datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q         <= 1'b0;
            bus.add_a    <= '0;
            bus.add_b    <= '0;
            bus.add_cin  <= 1'b0;
            bus.sticky   <= 1'b0;
            bus.eff_sub  <= 1'b0;
            bus.res_exp  <= 8'd0;
            bus.res_sign <= 1'b0;
            bus.res_nan  <= 1'b0;
            bus.res_inf  <= 1'b0;
        end else if (adv2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                bus.add_a    <= special ? '0 : sig_big_q;
                bus.add_b    <= special ? '0 : (eff_sub1_q ? ~shifted : shifted);
                // Ones'-complement plus cin is exact only if nothing was shifted out.
                bus.add_cin  <= ~special & eff_sub1_q & ~shift_sticky;
                bus.sticky   <= ~special & shift_sticky;
                bus.eff_sub  <= eff_sub1_q;
                bus.res_exp  <= exp1_q;
                bus.res_sign <= sign1_q;
                bus.res_nan  <= nan1_q;
                bus.res_inf  <= inf1_q;
            end
        end
    end

endmodule

// File: doc/fpu_addsub_align.md
# fpu_addsub_align

Operand alignment stage of the single-precision FPU add/sub datapath. It sits directly upstream of the 26-bit parallel-prefix mantissa adder. The block unpacks two IEEE-754 binary32 operands and orders them by magnitude. It right-shifts the smaller significand with sticky collection and presents adder-ready A/B/Cin operands through a 2-stage valid/ready pipeline. Special-operand flags, result exponent and sign travel alongside the operands to the downstream normalise/round stage.

## Interface
- `SHW`, default 26: significand width at the adder, laid out as {hidden, frac[22:0], guard, round}. Fixed by the adder; not meant to be overridden.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  an operand pair is presented.
- `in_ready`  out  1  the block accepts the pair this cycle.
- `op_a`  in  32  binary32 operand A.
- `op_b`  in  32  binary32 operand B.
- `sub`  in  1  1 = compute A−B; 0 = compute A+B.
- `out_valid`  out  1  output bundle is valid.
- `out_ready`  in  1  downstream accepts the bundle.
- `add_a`  out  26  larger-magnitude significand, to adder A.
- `add_b`  out  26  aligned smaller significand, inverted when subtracting, to adder B.
- `add_cin`  out  1  adder carry-in.
- `sticky`  out  1  OR of all significand bits shifted out below the round position.
- `eff_sub`  out  1  effective operation is a subtraction.
- `res_exp`  out  8  exponent of the larger operand, as effective exponent.
- `res_sign`  out  1  sign of the larger-magnitude operand.
- `res_nan`  out  1  result is NaN.
- `res_inf`  out  1  result is ±infinity, with sign `res_sign`.

## Operation
- Unpack: sign, exponent e, fraction f.
  - If e==0 (zero/subnormal): hidden=0, effective exponent 1.
  - Otherwise: hidden=1, effective exponent e.
- B sign is replaced by `sign_b ^ sub`.
- Stage 1 (compare/swap), registered:
  - Magnitude compare on {e,f}. The larger operand is "big"; on a tie, A is big.
  - d = eff_exp_big − eff_exp_small, range 0..253.
  - eff_sub = sign_big ^ sign_small.
  - Special-case detection happens here.
- Stage 2 (align), registered:
  - sig_small = {hidden, f, 2'b00} >> d. For d ≥ 26, sig_small = 0.
  - sticky = OR of the bits shifted out. For d ≥ 26, sticky = OR of the whole small significand.
  - add_a = {hidden_big, f_big, 2'b00}.
  - If eff_sub: add_b = ~sig_small and add_cin = ~sticky.
  - If not eff_sub: add_b = sig_small and add_cin = 0.
- Special cases:
  - Any NaN input, or Inf−Inf under effective subtraction: res_nan=1.
  - Any other Inf input: res_inf=1, res_sign = sign of the Inf.
  - When res_nan or res_inf is set: add_a, add_b, add_cin and sticky are 0.
- Exact-zero sign handling belongs to the downstream stage; this block reports the sign of big unchanged.

## Timing
- Latency: 2 cycles from input acceptance to out_valid. Throughput is 1 pair per cycle with no stalls.
- Each stage register (v1, v2 plus data) loads when it is empty or its contents are moving on that cycle.
  - in_ready = ~v1 | ~v2 | out_ready (combinational).
  - Stage 2 advances when ~v2 | out_ready.
- While out_valid=1 and out_ready=0, all outputs hold stable. No bundle is dropped, duplicated or reordered.
- Simultaneous accept at the input and drain at the output in one cycle is legal and keeps full throughput.
- Reset (asynchronous, effective immediately, mid-operation included):
  - v1=v2=0, so out_valid=0.
  - All data outputs are 0.
  - in_ready=1.
  - In-flight pairs are discarded.

## Test plan
- 1.0+1.0 (0x3F800000, 0x3F800000, sub=0) → 2 cycles later: add_a=add_b=0x2000000, add_cin=0, sticky=0, eff_sub=0, res_exp=0x7F.
- 1.0−0.5 (0x3F800000, 0x3F000000, sub=1) → add_a=0x2000000, add_b=0x2FFFFFF, add_cin=1, sticky=0, eff_sub=1, res_exp=0x7F, res_sign=0.
- 2^26+1.0 (0x4C800000, 0x3F800000, sub=0), where d=26 → add_b=0, sticky=1, add_cin=0, res_exp=0x99.
- Inf−Inf (0x7F800000, 0x7F800000, sub=1) → res_nan=1, res_inf=0, add_a=add_b=0. A second case, 0xFF800000+1.0 → res_inf=1, res_sign=1.
- Backpressure: hold out_ready=0 and drive 3 back-to-back valid pairs.
  - in_ready must drop after 2 pairs are accepted, and the first bundle must hold.
  - After out_ready is released, all 3 results arrive in order with no loss or duplication.
- Reset mid-stream: pull rst_n low while v1=v2=1 → out_valid=0 before the next clock edge. After release, in_ready=1 and the first new pair emerges 2 cycles after acceptance.
